sample_reader: RTL and testbench

Read-side engine for the shared audio sample memory. On a start request, it snapshots the writer's current write address and reads back the most recent `BLOCK_LEN` samples, oldest first. It drives the memory's registered read port and presents the samples on a valid/ready stream with backpressure. It sits between the sample memory and the downstream visualization pipeline (FFT/display), and owns the memory's `rdaddr` input.

---
 rtl/audio_viz_pkg.sv | 8 +
 rtl/sample_reader_if.sv | 14 +
 rtl/sample_fifo.sv | 40 ++++
 rtl/sample_reader.sv | 105 ++++++++++
 tb/tb_sample_reader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/audio_viz_pkg.sv
// Shared types and constants for the audio visualization read path.
package audio_viz_pkg;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int ADDR_LENGTH_DEF = 14;
  localparam int RD_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} rd_state_e;
endpackage

// File: rtl/sample_reader_if.sv
// Valid/ready sample stream from the reader to the visualization pipeline.
interface sample_reader_if
  import audio_viz_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; entry 0 is the registered head, later entries shift down on pop.
module sample_fifo
  import audio_viz_pkg::*;
#(
  parameter int  W     = DATA_WIDTH_DEF,
  parameter int  DEPTH = RD_FIFO_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          valid,
  output logic [CW-1:0] count
);
  logic [W-1:0]  q [DEPTH];
  logic          pop_ok;
  logic [PW-1:0] wr_idx;

  assign valid  = (count != '0);
  assign pop_ok = pop && valid;
  assign head   = q[0];
  // Write slot accounts for a simultaneous pop shifting everything down.
  assign wr_idx = PW'(count - CW'(pop_ok));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (pop_ok)
        for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
      if (push) q[wr_idx] <= din;
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/sample_reader.sv
// Reads the latest BLOCK_LEN samples (oldest first) from the sample memory onto a stream.
// Optional SAMPLE_READER_STRIDE_EN adds a decimating stride input.
module sample_reader
  import audio_viz_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_LENGTH = ADDR_LENGTH_DEF,
  parameter int BLOCK_LEN   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_LENGTH-1:0] wr_ptr,
`ifdef SAMPLE_READER_STRIDE_EN
  input  logic [3:0]             stride,
`endif
  output logic [ADDR_LENGTH-1:0] rdaddr,
  input  logic [DATA_WIDTH-1:0]  rddata,
  sample_reader_if.master        m,
  output logic                   busy,
  output logic                   done
);
  localparam int             CW  = $clog2(BLOCK_LEN + 1);
  localparam logic [CW-1:0]  BLK = CW'(BLOCK_LEN);
  localparam int             FCW = $clog2(RD_FIFO_DEPTH + 1);

  rd_state_e              state, state_nxt;
  logic [CW-1:0]          issued, sent;
  logic [ADDR_LENGTH-1:0] nxt_addr, step, start_step, start_base;
  logic [1:0]             vld_pipe;
  logic [FCW-1:0]         fifo_count;
  logic [FCW:0]           occ;
  logic                   credit, issue, xfer;

`ifdef SAMPLE_READER_STRIDE_EN
  assign start_step = (stride == 4'd0) ? ADDR_LENGTH'(1) : ADDR_LENGTH'(stride);
`else
  assign start_step = ADDR_LENGTH'(1);
`endif
  assign start_base = wr_ptr - ADDR_LENGTH'(BLOCK_LEN * int'(start_step));

  // Reads in flight count against FIFO space so the output stage never overflows.
  assign occ    = (FCW+1)'(fifo_count) + (FCW+1)'(vld_pipe[0]) + (FCW+1)'(vld_pipe[1]);
  assign credit = occ < (FCW+1)'(RD_FIFO_DEPTH);
  assign xfer   = m.m_valid && m.m_ready;
  assign busy   = (state != IDLE);
  assign m.m_last = m.m_valid && (sent == BLK - CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      // The first read goes out with the start so rdaddr=base the next cycle.
      IDLE:  if (start) begin state_nxt = FETCH; issue = 1'b1; end
      FETCH: if (issued == BLK) state_nxt = DRAIN;
             else if (credit)   issue = 1'b1;
      DRAIN: if (sent == BLK) begin state_nxt = IDLE; done = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdaddr   <= '0;
      nxt_addr <= '0;
      step     <= ADDR_LENGTH'(1);
      issued   <= '0;
      sent     <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], issue};
      if (xfer) sent <= sent + CW'(1);
      if (issue) begin
        if (state == IDLE) begin
          rdaddr   <= start_base;
          nxt_addr <= start_base + start_step;
          step     <= start_step;
          issued   <= CW'(1);
          sent     <= '0;
        end else begin
          rdaddr   <= nxt_addr;
          nxt_addr <= nxt_addr + step;
          issued   <= issued + CW'(1);
        end
      end
    end
  end

  sample_fifo #(.W(DATA_WIDTH), .DEPTH(RD_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_pipe[1]),
    .din   (rddata),
    .pop   (m.m_ready),
    .head  (m.m_data),
    .valid (m.m_valid),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_sample_reader.sv
// Directed bench for sample_reader: three instances (BLOCK_LEN 8, 1024, 1) plus a strided one.
module tb_sample_reader;
  import audio_viz_pkg::*;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic          start_a, start_b, start_c;
  logic [AW-1:0] wr_a, wr_b, wr_c;
  logic [AW-1:0] rdaddr_a, rdaddr_b, rdaddr_c;
  logic [DW-1:0] rdd_a, rdd_b, rdd_c;
  logic          busy_a, busy_b, busy_c, done_a, done_b, done_c;
`ifdef SAMPLE_READER_STRIDE_EN
  logic [3:0]    stride0 = 4'd0;
  logic [3:0]    stride_d;
  logic          start_d, busy_d, done_d;
  logic [AW-1:0] wr_d, rdaddr_d;
  logic [DW-1:0] rdd_d;
  sample_reader_if #(.DATA_WIDTH(DW)) if_d ();
`endif

  sample_reader_if #(.DATA_WIDTH(DW)) if_a ();
  sample_reader_if #(.DATA_WIDTH(DW)) if_b ();
  sample_reader_if #(.DATA_WIDTH(DW)) if_c ();

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a, a[11:0], 6'h2a} ^ 32'h5a5a_0000;
  endfunction

  always @(posedge clk) begin
    rdd_a <= memf(rdaddr_a);
    rdd_b <= memf(rdaddr_b);
    rdd_c <= memf(rdaddr_c);
`ifdef SAMPLE_READER_STRIDE_EN
    rdd_d <= memf(rdaddr_d);
`endif
  end

  sample_reader #(.DATA_WIDTH(DW), .ADDR_LENGTH(AW), .BLOCK_LEN(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .wr_ptr(wr_a),
`ifdef SAMPLE_READER_STRIDE_EN
    .stride(stride0),
`endif
    .rdaddr(rdaddr_a), .rddata(rdd_a), .m(if_a.master), .busy(busy_a), .done(done_a));

  sample_reader #(.DATA_WIDTH(DW), .ADDR_LENGTH(AW), .BLOCK_LEN(1024)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .wr_ptr(wr_b),
`ifdef SAMPLE_READER_STRIDE_EN
    .stride(stride0),
`endif
    .rdaddr(rdaddr_b), .rddata(rdd_b), .m(if_b.master), .busy(busy_b), .done(done_b));

  sample_reader #(.DATA_WIDTH(DW), .ADDR_LENGTH(AW), .BLOCK_LEN(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .wr_ptr(wr_c),
`ifdef SAMPLE_READER_STRIDE_EN
    .stride(stride0),
`endif
    .rdaddr(rdaddr_c), .rddata(rdd_c), .m(if_c.master), .busy(busy_c), .done(done_c));

`ifdef SAMPLE_READER_STRIDE_EN
  sample_reader #(.DATA_WIDTH(DW), .ADDR_LENGTH(AW), .BLOCK_LEN(4)) dut_d (
    .clk(clk), .reset(reset), .start(start_d), .wr_ptr(wr_d), .stride(stride_d),
    .rdaddr(rdaddr_d), .rddata(rdd_d), .m(if_d.master), .busy(busy_d), .done(done_d));
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Streams one block from dut_b against a scoreboard; optional mid-block start and reset.
  task automatic run_b(input logic [AW-1:0] wr, input bit rnd, input int restart_at,
                       input int reset_at, output int k, output bit saw_done);
    logic [AW-1:0] base;
    logic [DW-1:0] prev_data;
    bit            prev_stall;
    base = wr - AW'(1024);
    k = 0;
    saw_done = 0;
    prev_stall = 0;
    prev_data = '0;
    wr_b = wr;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if_b.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_b = (cyc == restart_at);
      if (prev_stall) chk("b_stall_hold", {if_b.m_valid, if_b.m_data}, {1'b1, prev_data});
      chk("b_fifo_occ", 64'(dut_b.u_fifo.count <= 4), 64'd1);
      if (if_b.m_valid && if_b.m_ready) begin
        chk("b_data", if_b.m_data, memf(base + AW'(k)));
        chk("b_last", if_b.m_last, 64'(k == 1023));
        k++;
      end
      prev_stall = if_b.m_valid && !if_b.m_ready;
      prev_data  = if_b.m_data;
      tick;
      start_b = 1'b0;
      if (k == reset_at) begin
        reset = 1'b1;
        tick;
        reset = 1'b0;
        return;
      end
      if (done_b) begin
        saw_done = 1;
        return;
      end
    end
  endtask

  initial begin
    int  k;
    bit  sd;
    int  n;
    reset = 1'b1;
    start_a = 0; start_b = 0; start_c = 0;
    wr_a = '0; wr_b = '0; wr_c = '0;
    if_a.m_ready = 1'b1; if_b.m_ready = 1'b1; if_c.m_ready = 1'b1;
`ifdef SAMPLE_READER_STRIDE_EN
    start_d = 0; wr_d = '0; stride_d = 4'd0; if_d.m_ready = 1'b1;
`endif
    repeat (3) tick;
    reset = 1'b0;
    tick;
    chk("rst_rdaddr", rdaddr_a, 0);
    chk("rst_m_data", if_a.m_data, 0);
    chk("rst_m_valid", if_a.m_valid, 0);
    chk("rst_m_last", if_a.m_last, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);

    // wr_ptr=100, 8 samples, ready held high
    wr_a = AW'(100);
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 8) chk("t1_rdaddr", rdaddr_a, 64'(92 + c - 1));
      chk("t1_valid", if_a.m_valid, 64'(c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) chk("t1_data", if_a.m_data, memf(AW'(92 + c - 3)));
      chk("t1_last", if_a.m_last, 64'(c == 10));
      chk("t1_done", done_a, 64'(c == 11));
      chk("t1_busy", busy_a, 64'(c <= 11));
      tick;
    end

    // wr_ptr=3 wraps below zero
    wr_a = AW'(3);
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      automatic logic [AW-1:0] e = (c <= 5) ? AW'(16378 + c) : AW'(c - 6);
      chk("t2_rdaddr", rdaddr_a, e);
      tick;
    end
    n = 0;
    while (!done_a && n < 50) begin tick; n++; end
    chk("t2_done", done_a, 1);

    // single-sample block at wr_ptr=0
    wr_c = '0;
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    chk("t5_rdaddr", rdaddr_c, 16383);
    chk("t5_busy", busy_c, 1);
    tick;
    chk("t5_valid_early", if_c.m_valid, 0);
    tick;
    chk("t5_valid", if_c.m_valid, 1);
    chk("t5_last", if_c.m_last, 1);
    chk("t5_data", if_c.m_data, memf(AW'(16383)));
    tick;
    chk("t5_valid_after", if_c.m_valid, 0);
    chk("t5_done", done_c, 1);
    tick;
    chk("t5_idle", busy_c, 0);
    chk("t5_done_pulse", done_c, 0);

    // 1024 samples, random backpressure
    run_b(AW'(5000), 1'b1, -1, -1, k, sd);
    chk("t3_count", 64'(k), 1024);
    chk("t3_done", 64'(sd), 1);
    tick;
    chk("t3_idle", busy_b, 0);

    // second start mid-block is ignored; reset after 500 samples
    run_b(AW'(9000), 1'b0, 100, 500, k, sd);
    chk("t4_count", 64'(k), 500);
    chk("t4_rdaddr", rdaddr_b, 0);
    chk("t4_m_data", if_b.m_data, 0);
    chk("t4_m_valid", if_b.m_valid, 0);
    chk("t4_m_last", if_b.m_last, 0);
    chk("t4_busy", busy_b, 0);
    chk("t4_done", done_b, 0);
    run_b(AW'(200), 1'b1, -1, -1, k, sd);
    chk("t4_fresh_count", 64'(k), 1024);
    chk("t4_fresh_done", 64'(sd), 1);

`ifdef SAMPLE_READER_STRIDE_EN
    // stride 4, wr_ptr=64, 4 samples
    wr_d = AW'(64);
    stride_d = 4'd4;
    start_d = 1'b1;
    tick;
    start_d = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("t6_rdaddr", rdaddr_d, 64'(48 + 4 * (c - 1)));
      tick;
    end
    n = 0;
    while (!done_d && n < 50) begin tick; n++; end
    chk("t6_done", done_d, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
